// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback through one shared ALU and one memory port.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state, state_next;
  logic [2:0] alu_funct;
  logic       alu_f3_ok;
  logic       br_f3_ok;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    case (op)
      OP_LW, OP_I: imm_src = 3'b000;
      OP_SW:       imm_src = 3'b001;
      OP_BR:       imm_src = 3'b010;
      OP_JAL:      imm_src = 3'b011;
      OP_LUI:      imm_src = 3'b100;
      default:     imm_src = 3'b000;
    endcase
  end

  assign alu_f3_ok = funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
  assign br_f3_ok  = funct3 inside {3'b000, 3'b001};

  always_comb begin
    case (funct3)
      3'b000:  alu_funct = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_funct = ALU_SLT;
      3'b110:  alu_funct = ALU_OR;
      3'b111:  alu_funct = ALU_AND;
      default: alu_funct = ALU_ADD;
    endcase
  end

  always_comb begin
    state_next  = state;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    result_src  = 2'b00;
    adr_src     = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    retire      = 1'b0;
    illegal     = 1'b0;
    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        // oldPC + imm lands in ALUOut so BRANCH can load it directly
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = alu_f3_ok ? EXECR : TRAP;
          OP_I:         state_next = alu_f3_ok ? EXECI : TRAP;
          OP_BR:        state_next = br_f3_ok ? BRANCH : TRAP;
          OP_JAL:       state_next = JAL;
          OP_LUI:       state_next = LUI;
          default:      state_next = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        retire    = mem_ready;
        if (mem_ready) state_next = FETCH;
      end
      EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_funct;
        state_next  = ALUWB;
      end
      EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_funct;
        state_next  = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        retire      = 1'b1;
        pc_write    = funct3[0] ? ~zero : zero;
        state_next  = FETCH;
      end
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = ALUWB;
      end
      LUI: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b01;
        state_next = ALUWB;
      end
      TRAP: illegal = 1'b1;
      default: state_next = TRAP;
    endcase
    // Reset overrides the strobes without waiting for the edge so an
    // in-flight instruction cannot commit anything while reset is held.
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller, driven by an
// instruction-level script that expands each instruction into expected cycles.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1110011;

  localparam logic [19:0] ALL    = 20'hFFFFF;
  localparam logic [19:0] STROBE = 20'h0007F;

  logic       clk = 1'b0;
  logic       reset, funct7b5, zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [2:0] imm_src, alu_control;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic       adr_src, mem_req, mem_write, ir_write, pc_write, reg_write, retire, illegal;
  logic [19:0] obs;

  int nvec = 0;
  int nerr = 0;
  int icyc;
  int ret_at;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .imm_src(imm_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .result_src(result_src),
    .adr_src(adr_src), .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .retire(retire), .illegal(illegal)
  );

  assign obs = {imm_src, alu_src_a, alu_src_b, alu_control, result_src, adr_src,
                mem_req, mem_write, ir_write, pc_write, reg_write, retire, illegal};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [19:0] v(input logic [2:0] imm, input logic [1:0] a,
                                    input logic [1:0] b, input logic [2:0] alu,
                                    input logic [1:0] rs, input logic adr,
                                    input logic req, input logic mw, input logic ir,
                                    input logic pc, input logic rw, input logic ret,
                                    input logic ill);
    return {imm, a, b, alu, rs, adr, req, mw, ir, pc, rw, ret, ill};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == OP_SW)  return 3'b001;
    if (o == OP_BR)  return 3'b010;
    if (o == OP_JAL) return 3'b011;
    if (o == OP_LUI) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic legal(input logic [6:0] o, input logic [2:0] f3);
    if (o == OP_LW || o == OP_SW || o == OP_JAL || o == OP_LUI) return 1'b1;
    if (o == OP_R || o == OP_I) return (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7);
    if (o == OP_BR) return (f3 == 3'd0 || f3 == 3'd1);
    return 1'b0;
  endfunction

  function automatic logic [2:0] alu_of(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (is_r && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %05h expected %05h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rdy, input logic z, input logic rst,
                      input logic [19:0] exp, input logic [19:0] mask, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    zero      = z;
    reset     = rst;
    #1;
    check(tag, obs & mask, exp & mask);
    icyc++;
    if (retire) ret_at = icyc;
  endtask

  // fw/mw: memory wait cycles (-1 = random); zb: branch zero flag (-1 = random)
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int fw_in, input int mw_in, input int zb);
    int fw, mw, lat;
    logic z;
    logic [2:0] imm;
    logic [19:0] memv;
    op = o; funct3 = f3; funct7b5 = f7;
    imm = imm_of(o);
    fw = (fw_in < 0) ? int'($urandom_range(0, 2)) : fw_in;
    mw = (mw_in < 0) ? int'($urandom_range(0, 2)) : mw_in;
    z  = (zb < 0) ? rb() : 1'(zb);
    icyc = 0; ret_at = 0; lat = 4;

    for (int k = 0; k < fw; k++)
      step(1'b0, rb(), 1'b0, v(imm, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0,
           1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), ALL, "fetch_wait");
    step(1'b1, rb(), 1'b0, v(imm, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0,
         1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), ALL, "fetch");
    step(rb(), rb(), 1'b0, v(imm, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), ALL, "decode");

    if (!legal(o, f3)) begin
      for (int k = 0; k < 10; k++)
        step(rb(), rb(), 1'b0, v(imm, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), ALL, "trap");
      step(rb(), rb(), 1'b1, '0, STROBE, "trap_reset");
      return;
    end

    if (o == OP_LW || o == OP_SW) begin
      step(rb(), rb(), 1'b0, v(imm, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), ALL, "memadr");
      memv = v(imm, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1,
               1'b1, (o == OP_SW), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < mw; k++)
        step(1'b0, rb(), 1'b0, memv, ALL, "mem_wait");
      if (o == OP_SW) begin
        step(1'b1, rb(), 1'b0, memv | 20'h2, ALL, "memwrite");
        lat = 4 + fw + mw;
      end else begin
        step(1'b1, rb(), 1'b0, memv, ALL, "memread");
        step(rb(), rb(), 1'b0, v(imm, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), ALL, "memwb");
        lat = 5 + fw + mw;
      end
    end else if (o == OP_BR) begin
      step(rb(), z, 1'b0, v(imm, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0,
           1'b0, 1'b0, 1'b0, (f3 == 3'd0) ? z : ~z, 1'b0, 1'b1, 1'b0), ALL, "branch");
      lat = 3 + fw;
    end else begin
      if (o == OP_R)
        step(rb(), rb(), 1'b0, v(imm, 2'b10, 2'b00, alu_of(1'b1, f3, f7), 2'b00, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), ALL, "exec_r");
      else if (o == OP_I)
        step(rb(), rb(), 1'b0, v(imm, 2'b10, 2'b01, alu_of(1'b0, f3, f7), 2'b00, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), ALL, "exec_i");
      else if (o == OP_JAL)
        step(rb(), rb(), 1'b0, v(imm, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), ALL, "jal");
      else
        step(rb(), rb(), 1'b0, v(imm, 2'b11, 2'b01, 3'b000, 2'b00, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), ALL, "lui");
      step(rb(), rb(), 1'b0, v(imm, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), ALL, "aluwb");
      lat = 4 + fw;
    end
    check("latency", 20'(ret_at), 20'(lat));
  endtask

  task automatic reset_mid_lw();
    logic [19:0] rd;
    op = OP_LW; funct3 = 3'd2; funct7b5 = 1'b0;
    step(1'b1, rb(), 1'b0, v(3'b000, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0,
         1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), ALL, "rst_fetch");
    step(rb(), rb(), 1'b0, v(3'b000, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), ALL, "rst_decode");
    step(rb(), rb(), 1'b0, v(3'b000, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), ALL, "rst_memadr");
    rd = v(3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1,
           1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, rb(), 1'b0, rd, ALL, "rst_memread");
    step(1'b0, rb(), 1'b0, rd, ALL, "rst_memread");
    for (int k = 0; k < 3; k++)
      step(rb(), rb(), 1'b1, '0, STROBE, "rst_hold");
  endtask

  initial begin
    logic [6:0] ops [8];
    logic [6:0] o;
    logic [2:0] f3;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI, OP_BAD};
    reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    step(1'b0, 1'b0, 1'b1, '0, STROBE, "reset");
    step(1'b1, 1'b1, 1'b1, '0, STROBE, "reset");

    run_instr(OP_LW,  3'd2, 1'b0, 2, 2, -1);
    run_instr(OP_SW,  3'd2, 1'b0, 0, 0, -1);
    run_instr(OP_BR,  3'd0, 1'b0, 0, 0, 1);
    run_instr(OP_BR,  3'd1, 1'b0, 0, 0, 1);
    run_instr(OP_BR,  3'd1, 1'b0, 0, 0, 0);
    run_instr(OP_R,   3'd0, 1'b1, 0, 0, -1);
    run_instr(OP_I,   3'd0, 1'b1, 0, 0, -1);
    run_instr(OP_R,   3'd6, 1'b0, 0, 0, -1);
    run_instr(OP_I,   3'd7, 1'b0, 0, 0, -1);
    run_instr(OP_R,   3'd2, 1'b0, 0, 0, -1);
    run_instr(OP_JAL, 3'd0, 1'b0, 0, 0, -1);
    run_instr(OP_LUI, 3'd0, 1'b0, 0, 0, -1);
    run_instr(OP_BAD, 3'd0, 1'b0, 0, 0, -1);
    run_instr(OP_BR,  3'd4, 1'b0, 0, 0, -1);
    reset_mid_lw();
    run_instr(OP_R,   3'd0, 1'b0, 0, 0, -1);

    for (int n = 0; n < 250; n++) begin
      o  = ops[$urandom_range(0, 7)];
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (o == OP_BR) f3 = {2'b00, rb()};
        else if (o == OP_R || o == OP_I) begin
          case ($urandom_range(0, 3))
            0:       f3 = 3'd0;
            1:       f3 = 3'd2;
            2:       f3 = 3'd6;
            default: f3 = 3'd7;
          endcase
        end
      end
      run_instr(o, f3, rb(), -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete within the time limit");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multi-cycle variant of the RV32I core. It sequences fetch, decode, execute, memory and writeback over several cycles through a single shared ALU and a single unified memory port. It drives the immediate generator's 3-bit `immsrc` select and the ALU function code, and holds off on a memory ready handshake. It sits beside the datapath and consumes only instruction fields and ALU flags from it.

## Interface
- No parameters. State encoding is fixed at 4 bits.
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `op`  in  7  instr[6:0] from the instruction register
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `zero`  in  1  ALU zero flag for the current cycle
- `mem_ready`  in  1  memory has completed the current request this cycle
- `imm_src`  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- `alu_src_a`  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero
- `alu_src_b`  out  2  00 rs2, 01 imm, 10 constant 4
- `alu_control`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `result_src`  out  2  00 ALUOut register, 01 read data, 10 ALU result
- `adr_src`  out  1  0 PC, 1 result
- `mem_req`, `mem_write`, `ir_write`, `pc_write`, `reg_write`  out  1 each  strobes
- `retire`  out  1  one-cycle pulse on the final cycle of each instruction
- `illegal`  out  1  high while in TRAP

## Operation
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - branch 1100011, with funct3 000 beq and 001 bne
  - jal 1101111
  - lui 0110111
- `imm_src` is decoded combinationally from `op` in every state:
  - lw and I-ALU → 000
  - sw → 001
  - branch → 010
  - jal → 011
  - lui → 100
  - anything else → 000
- Every output is 0 unless the state below lists it.
- States and what each drives:
  - **FETCH (0):**
    - Drives `mem_req`=1, `adr_src`=0, a=00, b=10, add, `result_src`=10.
    - `ir_write` = `pc_write` = `mem_ready`.
    - Stays in FETCH until `mem_ready`, then goes to DECODE.
  - **DECODE (1):**
    - Drives a=01, b=01, add. This precomputes the branch target into ALUOut.
    - Next state by `op`: lw/sw → MEMADR, R → EXECR, I-ALU → EXECI, branch → BRANCH, jal → JAL, lui → LUI.
    - Goes to TRAP on:
      - an unknown `op`;
      - branch `funct3` other than 000 or 001;
      - ALU `funct3` other than 000, 010, 110, 111.
  - **MEMADR (2):** drives a=10, b=01, add. Next is MEMREAD for lw, MEMWRITE for sw.
  - **MEMREAD (3):** drives `mem_req`, `adr_src`=1, `result_src`=00. Waits for `mem_ready`, then goes to MEMWB.
  - **MEMWB (4):** drives `result_src`=01, `reg_write`, `retire`. Next is FETCH.
  - **MEMWRITE (5):**
    - Drives `mem_req`, `mem_write`, `adr_src`=1, `result_src`=00.
    - Waits for `mem_ready`.
    - `retire` = `mem_ready`; goes to FETCH on `mem_ready`.
  - **EXECR (6):** drives a=10, b=00, funct decode. Next is ALUWB.
  - **EXECI (7):** drives a=10, b=01, funct decode. Next is ALUWB.
  - **ALUWB (8):** drives `result_src`=00, `reg_write`, `retire`. Next is FETCH.
  - **BRANCH (9):**
    - Drives a=10, b=00, sub, `result_src`=00, `retire`.
    - `pc_write` = `zero` for beq, `!zero` for bne.
    - Next is FETCH.
  - **JAL (10):** drives a=01, b=10, add, `result_src`=00 (target), `pc_write`. Next is ALUWB, which writes PC+4 to rd.
  - **LUI (11):** drives a=11, b=01, add. Next is ALUWB.
  - **TRAP (12):** drives `illegal`=1, all strobes 0. Stays in TRAP until `reset`.
- Funct decode for `alu_control`:
  - funct3 000 → sub if R-type and `funct7b5`, otherwise add.
  - 010 → slt.
  - 110 → or.
  - 111 → and.
- Unused encodings 13–15 go to TRAP on the next edge.

## Timing
- Reset:
  - `reset` sampled high forces state to FETCH on that edge.
  - While `reset` is high, `mem_req`, `mem_write`, `ir_write`, `pc_write`, `reg_write`, `retire` and `illegal` are forced to 0, combinationally.
  - A reset asserted mid-instruction, including during a memory wait, abandons that instruction with no `reg_write`, `pc_write` or `mem_write` strobe.
- Strobe style:
  - Moore outputs come from the state register.
  - `pc_write`, `ir_write` and `retire` are additionally gated by `mem_ready` or `zero` within the same cycle.
- Memory handshake:
  - `mem_req`, `adr_src` and `mem_write` stay stable for every wait cycle.
  - Completion is exactly the cycle in which `mem_ready` is 1.
  - `mem_ready` outside FETCH, MEMREAD and MEMWRITE is ignored.
- Latency with zero-wait memory (`mem_ready` tied high):
  - lw 5 cycles
  - sw 4
  - R, I-ALU, lui, jal 4
  - branch 3
  - each memory wait cycle adds 1.
- Exactly one `retire` pulse per completed instruction, never in TRAP.

## Test plan
- Reset held 3 cycles mid-MEMREAD, then released → state FETCH, `mem_req`=1, no `reg_write` or `pc_write` observed.
- Fetch `lw` (op 0000011) with `mem_ready` low for 2 cycles in both FETCH and MEMREAD → FETCH, DECODE, MEMADR, MEMREAD, MEMWB spanning 9 cycles; `imm_src`=000; one `reg_write` with `result_src`=01.
- `sw` with ready=1 → 4 cycles; `imm_src`=001; `mem_write`=1 for exactly one cycle with `adr_src`=1; no `reg_write`.
- `beq` with zero=1 → `pc_write`=1 in BRANCH with `alu_control`=001. `bne` with zero=1 → `pc_write`=0. Both give `imm_src`=010, 3 cycles.
- R-type with funct3=000, `funct7b5`=1 → `alu_control`=001. I-ALU with funct3=000, `funct7b5`=1 → 000. Funct3 110 → 011, 111 → 010, 010 → 101.
- `jal` → `imm_src`=011, `pc_write` in JAL, then `reg_write` in ALUWB. `lui` → `imm_src`=100, `alu_src_a`=11. Opcode 1110011 → TRAP: `illegal` stays high, strobes stay 0 for 10 cycles, cleared by `reset`.
